// File: rtl/vscale_htif_tohost_monitor_if.sv
// HTIF PCR port bundle between the tohost monitor (master) and the core's HTIF port (slave).
interface vscale_htif_tohost_monitor_if #(
    parameter int HTIF_PCR_WIDTH = 64,
    parameter int CSR_ADDR_WIDTH = 12
);
    logic                      htif_pcr_req_valid;
    logic                      htif_pcr_req_ready;
    logic                      htif_pcr_req_rw;
    logic [CSR_ADDR_WIDTH-1:0] htif_pcr_req_addr;
    logic [HTIF_PCR_WIDTH-1:0] htif_pcr_req_data;
    logic                      htif_pcr_resp_valid;
    logic                      htif_pcr_resp_ready;
    logic [HTIF_PCR_WIDTH-1:0] htif_pcr_resp_data;

    // valid/ready: a transfer happens on a rising clk edge where both are 1; the sender
    // holds valid and its payload stable until that edge, and ready may be raised at any time.
    modport master (
        output htif_pcr_req_valid, htif_pcr_req_rw, htif_pcr_req_addr, htif_pcr_req_data,
        output htif_pcr_resp_ready,
        input  htif_pcr_req_ready, htif_pcr_resp_valid, htif_pcr_resp_data
    );

    modport slave (
        input  htif_pcr_req_valid, htif_pcr_req_rw, htif_pcr_req_addr, htif_pcr_req_data,
        input  htif_pcr_resp_ready,
        output htif_pcr_req_ready, htif_pcr_resp_valid, htif_pcr_resp_data
    );
endinterface

// File: rtl/vscale_htif_tohost_monitor.sv
// HTIF host-side poller: reads CSR tohost until pass/fail, with a cycle watchdog and sticky result.
// Optional feature macro VSCALE_TOHOST_CLEAR_EN: write tohost back to 0 before reporting done.
module vscale_htif_tohost_monitor #(
    parameter int                        HTIF_PCR_WIDTH = 64,
    parameter int                        CSR_ADDR_WIDTH = 12,
    parameter logic [CSR_ADDR_WIDTH-1:0] TOHOST_ADDR    = 12'h780,
    parameter int                        CYCLE_W        = 64,
    parameter int                        POLL_GAP       = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [CYCLE_W-1:0]          max_cycles,
    vscale_htif_tohost_monitor_if.master htif,
    output logic                        done,
    output logic                        pass,
    output logic                        fail,
    output logic                        timeout,
    output logic [HTIF_PCR_WIDTH-2:0]   tohost_code,
    output logic [CYCLE_W-1:0]          cycle_count,
    output logic [2:0]                  state_dbg
);

    localparam int GAP_W = (POLL_GAP > 2) ? $clog2(POLL_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (POLL_GAP > 0) ? GAP_W'(POLL_GAP - 1) : '0;

`ifdef VSCALE_TOHOST_CLEAR_EN
    typedef enum logic [2:0] {
        S_REQ      = 3'd0,
        S_RESP     = 3'd1,
        S_GAP      = 3'd2,
        S_DONE     = 3'd3,
        S_CLR_REQ  = 3'd4,
        S_CLR_RESP = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_REQ  = 3'd0,
        S_RESP = 3'd1,
        S_GAP  = 3'd2,
        S_DONE = 3'd3
    } state_t;
`endif

    state_t                    state, state_next;
    logic [GAP_W-1:0]          gap_cnt, gap_next;
    logic                      pass_r, pass_next;
    logic                      fail_r, fail_next;
    logic                      timeout_r, timeout_next;
    logic [HTIF_PCR_WIDTH-2:0] code_r, code_next;
    logic                      req_valid;
    logic                      resp_ready;
    logic                      expired;
`ifdef VSCALE_TOHOST_CLEAR_EN
    logic                      req_rw;
`endif

    assign expired = (max_cycles != '0) && (cycle_count > max_cycles);

    always_comb begin
        state_next   = state;
        gap_next     = gap_cnt;
        pass_next    = pass_r;
        fail_next    = fail_r;
        timeout_next = timeout_r;
        code_next    = code_r;
        req_valid    = 1'b0;
        resp_ready   = 1'b0;
`ifdef VSCALE_TOHOST_CLEAR_EN
        req_rw       = 1'b0;
`endif
        case (state)
            S_GAP: begin
                if (gap_cnt == '0) state_next = S_REQ;
                else               gap_next   = gap_cnt - GAP_W'(1);
            end
            S_REQ: begin
                req_valid = 1'b1;
                if (htif.htif_pcr_req_ready) state_next = S_RESP;
            end
            S_RESP: begin
                resp_ready = 1'b1;
                if (htif.htif_pcr_resp_valid) begin
                    if (htif.htif_pcr_resp_data == '0) begin
                        state_next = S_GAP;
                        gap_next   = GAP_LOAD;
                    end else begin
                        pass_next = (htif.htif_pcr_resp_data == HTIF_PCR_WIDTH'(1));
                        fail_next = (htif.htif_pcr_resp_data != HTIF_PCR_WIDTH'(1));
                        code_next = htif.htif_pcr_resp_data[HTIF_PCR_WIDTH-1:1];
`ifdef VSCALE_TOHOST_CLEAR_EN
                        state_next = S_CLR_REQ;
`else
                        state_next = S_DONE;
`endif
                    end
                end
            end
`ifdef VSCALE_TOHOST_CLEAR_EN
            S_CLR_REQ: begin
                req_valid = 1'b1;
                req_rw    = 1'b1;
                if (htif.htif_pcr_req_ready) state_next = S_CLR_RESP;
            end
            S_CLR_RESP: begin
                resp_ready = 1'b1;
                if (htif.htif_pcr_resp_valid) state_next = S_DONE;
            end
`endif
            default: ;
        endcase

        // A result decoded in this same cycle (or captured earlier) outranks the watchdog.
        if (expired && (state != S_DONE)) begin
            state_next = S_DONE;
            if (!pass_next && !fail_next) timeout_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= S_GAP;
            gap_cnt     <= '0;
            pass_r      <= 1'b0;
            fail_r      <= 1'b0;
            timeout_r   <= 1'b0;
            code_r      <= '0;
            cycle_count <= '0;
        end else begin
            state     <= state_next;
            gap_cnt   <= gap_next;
            pass_r    <= pass_next;
            fail_r    <= fail_next;
            timeout_r <= timeout_next;
            code_r    <= code_next;
            // The count freezes on the edge that enters DONE, so it reads the last live cycle.
            if ((state != S_DONE) && (state_next != S_DONE) && (cycle_count != '1))
                cycle_count <= cycle_count + CYCLE_W'(1);
        end
    end

    assign done        = (state == S_DONE);
    assign pass        = pass_r & done;
    assign fail        = fail_r & done;
    assign timeout     = timeout_r & done;
    assign tohost_code = done ? code_r : '0;
    assign state_dbg   = state;

    assign htif.htif_pcr_req_valid  = req_valid;
    assign htif.htif_pcr_req_addr   = TOHOST_ADDR;
    assign htif.htif_pcr_req_data   = '0;
    assign htif.htif_pcr_resp_ready = resp_ready;
`ifdef VSCALE_TOHOST_CLEAR_EN
    assign htif.htif_pcr_req_rw     = req_rw;
`else
    assign htif.htif_pcr_req_rw     = 1'b0;
`endif

endmodule
